// File: rtl/result_readback_pkg.sv
// Types and constants shared by the result readback path and the test FSM that writes results.
// The base address and count match the write side of the result memory.
package result_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    RD_REQ,
    RD_WAIT,
    SEND,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] RESULT_HEADER         = 8'hA5;
  localparam int         RESULT_BASE_ADDR      = 1;
  localparam int         RESULT_COUNT          = 8;
  localparam int         RESULT_ADDR_WIDTH     = 13;
  localparam logic [7:0] RESULT_PASS_THRESHOLD = 8'd250;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_readback_if.sv
// Bus between result_readback (master) and its memory read port / host / test FSM (slave).
// Handshake: a byte moves on a posedge where tx_valid && tx_ready; while tx_valid=1 and
// tx_ready=0 the master holds tx_data and tx_valid; tx_ready means nothing while tx_valid=0.
interface result_readback_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int N_RESULTS  = 8
);
  logic                  start;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [7:0]            mem_dout;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;
  logic [N_RESULTS-1:0]  pass_mask;

  modport master (
    input  start, mem_dout, tx_ready,
    output mem_re, mem_raddr, tx_data, tx_valid, busy, done, pass_mask
  );

  modport slave (
    output start, mem_dout, tx_ready,
    input  mem_re, mem_raddr, tx_data, tx_valid, busy, done, pass_mask
  );
endinterface

// File: rtl/result_readback.sv
// Reads the per-test pass counts back from result memory after test_done and streams them
// to the host as HEADER, N, R0..R(N-1), CSUM, while building a per-test pass mask.
module result_readback
  import result_pkg::*;
#(
  parameter int         ADDR_WIDTH     = RESULT_ADDR_WIDTH,
  parameter int         N_RESULTS      = RESULT_COUNT,
  parameter int         BASE_ADDR      = RESULT_BASE_ADDR,
  parameter logic [7:0] PASS_THRESHOLD = RESULT_PASS_THRESHOLD,
  parameter logic [7:0] HEADER         = RESULT_HEADER
) (
  input  logic                clk_1,
  input  logic                rst,
  result_readback_if.master   bus,
  output state_t              o_state
);

  localparam int                    IDX_W    = index_width(N_RESULTS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_RESULTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [7:0]            LEN_BYTE = 8'(N_RESULTS);

  state_t                r_state;
  logic [IDX_W-1:0]      r_index;
  logic [7:0]            r_csum;
  logic                  r_mem_re;
  logic [ADDR_WIDTH-1:0] r_mem_raddr;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [N_RESULTS-1:0]  r_pass_mask;

  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_addr_cur;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  assign w_xfer      = r_tx_valid && bus.tx_ready;
  // Address math wraps modulo 2^ADDR_WIDTH by construction of the operand widths.
  assign w_addr_cur  = BASE + ADDR_WIDTH'(r_index);
  assign w_addr_next = w_addr_cur + ADDR_WIDTH'(1);

  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_state     <= IDLE;
      r_index     <= '0;
      r_csum      <= '0;
      r_mem_re    <= 1'b0;
      r_mem_raddr <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass_mask <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state     <= HDR;
          r_busy      <= 1'b1;
          r_tx_data   <= HEADER;
          r_tx_valid  <= 1'b1;
          r_pass_mask <= '0;
          r_csum      <= '0;
          r_index     <= '0;
        end
        HDR: if (w_xfer) begin
          r_tx_data <= LEN_BYTE;
          r_csum    <= LEN_BYTE;
          r_state   <= LEN;
        end
        LEN: if (w_xfer) begin
          r_tx_valid  <= 1'b0;
          r_mem_re    <= 1'b1;
          r_mem_raddr <= w_addr_cur;
          r_state     <= RD_REQ;
        end
        RD_REQ: begin
          r_mem_re <= 1'b0;
          r_state  <= RD_WAIT;
        end
        RD_WAIT: begin
          // tx_data doubles as the one-deep hold register for the result byte.
          r_tx_data            <= bus.mem_dout;
          r_tx_valid           <= 1'b1;
          r_csum               <= r_csum ^ bus.mem_dout;
          r_pass_mask[r_index] <= (bus.mem_dout >= PASS_THRESHOLD);
          r_state              <= SEND;
        end
        SEND: if (w_xfer) begin
          if (r_index == LAST_IDX) begin
            r_tx_data <= r_csum;
            r_state   <= CSUM;
          end else begin
            r_index     <= r_index + IDX_W'(1);
            r_tx_valid  <= 1'b0;
            r_mem_re    <= 1'b1;
            r_mem_raddr <= w_addr_next;
            r_state     <= RD_REQ;
          end
        end
        CSUM: if (w_xfer) begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= DONE;
        end
        DONE: if (!bus.start) begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_re    = r_mem_re;
  assign bus.mem_raddr = r_mem_raddr;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass_mask = r_pass_mask;
  assign o_state       = r_state;

endmodule

// File: tb/tb_result_readback.sv
// Bench for result_readback: default instance on addresses 1..8 and a 4-result instance
// whose read window wraps the top of the 13-bit address space.
module tb_result_readback;
  import result_pkg::*;

  logic clk_1 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_1 = ~clk_1;

  result_readback_if #(.ADDR_WIDTH(13), .N_RESULTS(8)) bus_a ();
  result_readback_if #(.ADDR_WIDTH(13), .N_RESULTS(4)) bus_b ();
  state_t st_a, st_b;

  result_readback dut_a (.clk_1(clk_1), .rst(rst), .bus(bus_a), .o_state(st_a));
  result_readback #(.N_RESULTS(4), .BASE_ADDR(8190)) dut_b (
    .clk_1(clk_1), .rst(rst), .bus(bus_b), .o_state(st_b));

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  mem [0:8191];
  logic [7:0]  exp_q[$];
  int          exp_addr_q[$];
  logic [7:0]  exp_mask;
  logic [7:0]  got_a[$], got_b[$];
  int          rd_a[$], rd_b[$];
  int          ready_mode_a = 0;  // 0: tied 1, 1: random, 2: tied 0
  bit          prev_stall_a = 1'b0;
  logic [7:0]  prev_data_a  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous-read memory: data appears one cycle after mem_re.
  always @(posedge clk_1) begin
    if (bus_a.mem_re) bus_a.mem_dout <= mem[bus_a.mem_raddr];
    if (bus_b.mem_re) bus_b.mem_dout <= mem[bus_b.mem_raddr];
  end

  // Observation at negedge: valid&&ready now means a transfer at the coming posedge.
  always @(negedge clk_1) begin
    if (!rst) begin
      if (bus_a.tx_valid && bus_a.tx_ready) got_a.push_back(bus_a.tx_data);
      if (bus_b.tx_valid && bus_b.tx_ready) got_b.push_back(bus_b.tx_data);
      if (bus_a.mem_re) rd_a.push_back(int'(bus_a.mem_raddr));
      if (bus_b.mem_re) rd_b.push_back(int'(bus_b.mem_raddr));
      if (prev_stall_a) begin
        check("stall_valid", 32'(bus_a.tx_valid), 32'd1);
        check("stall_data", 32'(bus_a.tx_data), 32'(prev_data_a));
      end
      prev_stall_a = bus_a.tx_valid && !bus_a.tx_ready;
      prev_data_a  = bus_a.tx_data;
    end else begin
      prev_stall_a = 1'b0;
    end
  end

  initial begin
    bus_a.tx_ready = 1'b1;
    forever begin
      @(posedge clk_1);
      #1;
      case (ready_mode_a)
        0:       bus_a.tx_ready = 1'b1;
        1:       bus_a.tx_ready = 1'($urandom_range(0, 1));
        default: bus_a.tx_ready = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_1);
      #1;
    end
  endtask

  // Reference frame straight from the frame rules: header, length, results, xor checksum.
  task automatic model_frame(input int base, input int n);
    logic [7:0] c, b;
    int a;
    exp_q.delete();
    exp_addr_q.delete();
    exp_mask = '0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    c = 8'(n);
    for (int i = 0; i < n; i++) begin
      a = (base + i) % 8192;
      b = mem[a];
      exp_addr_q.push_back(a);
      exp_q.push_back(b);
      c = c ^ b;
      if (b >= 8'd250) exp_mask[i] = 1'b1;
    end
    exp_q.push_back(c);
  endtask

  task automatic compare_frame(input string tag, input bit which);
    logic [7:0] got[$];
    int rd[$];
    got = which ? got_b : got_a;
    rd  = which ? rd_b : rd_a;
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_nreads"}, 32'(rd.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < rd.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 32'(rd[i]), 32'(exp_addr_q[i]));
  endtask

  task automatic wait_done(input bit which, input int limit, output int cycles);
    cycles = 0;
    while (((which ? bus_b.done : bus_a.done) !== 1'b1) && cycles < limit) begin
      @(posedge clk_1);
      #1;
      cycles++;
    end
    check("done_within_bound", 32'(which ? bus_b.done : bus_a.done), 32'd1);
  endtask

  task automatic clear_logs();
    got_a.delete(); got_b.delete(); rd_a.delete(); rd_b.delete();
  endtask

  initial begin
    int cyc;
    logic [7:0] init_vals [8];
    init_vals = '{8'd255, 8'd250, 8'd249, 8'd0, 8'd128, 8'd251, 8'd10, 8'd250};
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_b.tx_ready = 1'b1;

    // Reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus_a.tx_data), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_mask", 32'(bus_a.pass_mask), 32'd0);
    check("rst_mem_re", 32'(bus_a.mem_re), 32'd0);
    check("rst_raddr", 32'(bus_a.mem_raddr), 32'd0);
    check("rst_state", 32'(st_a), 32'(IDLE));

    // Directed frame, host always ready, exact completion time
    for (int i = 0; i < 8; i++) mem[1 + i] = init_vals[i];
    model_frame(1, 8);
    clear_logs();
    bus_a.start = 1'b1;
    wait_done(1'b0, 200, cyc);
    check("done_cycle", 32'(cyc), 32'd28);
    tick(1);
    compare_frame("frame1", 1'b0);
    check("csum_const", 32'(exp_q[10]), 32'h7F);
    check("mask1", 32'(bus_a.pass_mask), 32'hA3);
    check("busy_after_done", 32'(bus_a.busy), 32'd0);

    // start stays high: no retrigger
    tick(20);
    check("no_retrigger_bytes", 32'(got_a.size()), 32'd11);
    check("hold_done", 32'(bus_a.done), 32'd1);
    check("hold_mask", 32'(bus_a.pass_mask), 32'hA3);
    bus_a.start = 1'b0;
    tick(1);
    check("done_cleared", 32'(bus_a.done), 32'd0);
    check("back_idle", 32'(st_a), 32'(IDLE));
    check("mask_retained", 32'(bus_a.pass_mask), 32'hA3);

    // Same data, host stalls randomly
    ready_mode_a = 1;
    clear_logs();
    bus_a.start = 1'b1;
    wait_done(1'b0, 2000, cyc);
    tick(1);
    compare_frame("frame_stall", 1'b0);
    check("mask_stall", 32'(bus_a.pass_mask), 32'hA3);
    bus_a.start = 1'b0;
    tick(2);

    // Random result values, random stalls
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) mem[1 + i] = 8'($urandom_range(240, 255) & ($urandom_range(0, 3) == 0 ? 8'h7F : 8'hFF));
      model_frame(1, 8);
      clear_logs();
      bus_a.start = 1'b1;
      wait_done(1'b0, 2000, cyc);
      tick(1);
      compare_frame($sformatf("frame_rand%0d", k), 1'b0);
      check($sformatf("mask_rand%0d", k), 32'(bus_a.pass_mask), 32'(exp_mask));
      bus_a.start = 1'b0;
      tick(2);
    end

    // Host holds off in HDR for 100 cycles
    ready_mode_a = 2;
    clear_logs();
    bus_a.start = 1'b1;
    tick(100);
    check("hdr_valid", 32'(bus_a.tx_valid), 32'd1);
    check("hdr_data", 32'(bus_a.tx_data), 32'hA5);
    check("hdr_no_reads", 32'(rd_a.size()), 32'd0);
    check("hdr_state", 32'(st_a), 32'(HDR));

    // Abort while R3 is being presented, then a fresh frame with start still high
    ready_mode_a = 0;
    cyc = 0;
    while (!(got_a.size() == 5 && bus_a.tx_valid === 1'b1) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("reach_r3", 32'(got_a.size()), 32'd5);
    rst = 1'b1;
    tick(1);
    check("abort_valid", 32'(bus_a.tx_valid), 32'd0);
    check("abort_busy", 32'(bus_a.busy), 32'd0);
    check("abort_done", 32'(bus_a.done), 32'd0);
    check("abort_mask", 32'(bus_a.pass_mask), 32'd0);
    check("abort_mem_re", 32'(bus_a.mem_re), 32'd0);
    rst = 1'b0;
    clear_logs();
    model_frame(1, 8);
    wait_done(1'b0, 200, cyc);
    tick(1);
    compare_frame("frame_after_rst", 1'b0);
    check("mask_after_rst", 32'(bus_a.pass_mask), 32'(exp_mask));
    bus_a.start = 1'b0;
    tick(2);

    // Read window wrapping past the top of the address space
    mem[8190] = 8'd252; mem[8191] = 8'd3; mem[0] = 8'd250; mem[1] = 8'd249;
    model_frame(8190, 4);
    clear_logs();
    bus_b.start = 1'b1;
    wait_done(1'b1, 200, cyc);
    check("wrap_done_cycle", 32'(cyc), 32'd16);
    tick(1);
    compare_frame("frame_wrap", 1'b1);
    check("wrap_addr2_zero", 32'(rd_b.size() > 2 ? rd_b[2] : -1), 32'd0);
    check("mask_wrap", 32'(bus_b.pass_mask), 32'(exp_mask[3:0]));
    bus_b.start = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
